// File: rtl/hazard_forward_unit_if.sv
// Decode-stage bus between fetch and the hazard/forward unit.
// Fetch side is the master, the hazard unit is the slave.
interface hazard_forward_unit_if #(
  parameter int SELW = 2,
  parameter int CNTW = 16
);
  logic            ins_valid;
  logic [31:0]     ins;
  logic            flush;
  logic            stall;
  logic            out_valid;
  logic [5:0]      op_dec;
  logic [15:0]     imm;
  logic            imm_sel;
  logic [4:0]      dest;
  logic [SELW-1:0] fwd_sel_a;
  logic [SELW-1:0] fwd_sel_b;
  logic            mem_en_ex;
  logic            mem_rw_ex;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output ins_valid, ins, flush,
    input  stall, out_valid, op_dec, imm, imm_sel, dest,
           fwd_sel_a, fwd_sel_b, mem_en_ex, mem_rw_ex, stall_cnt
  );

  modport slave (
    input  ins_valid, ins, flush,
    output stall, out_valid, op_dec, imm, imm_sel, dest,
           fwd_sel_a, fwd_sel_b, mem_en_ex, mem_rw_ex, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Decode-stage dependency checker: DEPTH-entry destination scoreboard driving
// operand forward selects, load-use stall, issue registers and a stall counter.
module hazard_forward_unit #(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = 2,
  parameter int CNTW     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_forward_unit_if.slave  bus
);
  localparam logic [5:0] OP_LD  = 6'b010100;
  localparam logic [5:0] OP_ST  = 6'b010101;
  localparam logic [5:0] OP_JMP = 6'b011000;

  logic [5:0] op;
  logic [4:0] rd, rs_a, rs_b, src_b;
  logic       is_ld, is_st, is_jmp, is_cj, is_imm, is_rt;
  logic       wr_reg, use_a, use_b, issue;

  assign op   = bus.ins[31:26];
  assign rd   = bus.ins[25:21];
  assign rs_a = bus.ins[20:16];
  assign rs_b = bus.ins[15:11];

  always_comb begin
    is_ld  = (op == OP_LD);
    is_st  = (op == OP_ST);
    is_jmp = (op == OP_JMP);
    is_cj  = (op[5:2] == 4'b0111);
    is_imm = (op[5:3] == 3'b001);
    is_rt  = (op[5:3] == 3'b000);
    wr_reg = (is_rt | is_imm | is_ld) & (rd != 5'd0);
    use_a  = ~(is_jmp | is_cj);
    use_b  = is_rt | is_st;
    // stores read their data register through the rd field
    src_b  = is_st ? rd : rs_b;
  end

  // scoreboard, entry 0 = youngest
  logic [DEPTH-1:0]      sb_v, sb_ld;
  logic [DEPTH-1:0][4:0] sb_rd;
  logic [SELW-1:0]       sel_a, sel_b;
  logic                  haz_a, haz_b;

  // walk oldest to youngest so the nearest match overwrites older ones
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (use_a && rs_a != 5'd0 && sb_v[i] && sb_rd[i] == rs_a) begin
        sel_a = SELW'(i + 1);
        haz_a = sb_ld[i] && (i < LOAD_LAT);
      end
      if (use_b && src_b != 5'd0 && sb_v[i] && sb_rd[i] == src_b) begin
        sel_b = SELW'(i + 1);
        haz_b = sb_ld[i] && (i < LOAD_LAT);
      end
    end
  end

  assign bus.stall = ~reset & bus.ins_valid & ~bus.flush & (haz_a | haz_b);
  assign issue     = bus.ins_valid & ~bus.stall & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_v          <= '0;
      sb_ld         <= '0;
      sb_rd         <= '0;
      bus.out_valid <= 1'b0;
      bus.op_dec    <= '0;
      bus.imm       <= '0;
      bus.imm_sel   <= 1'b0;
      bus.dest      <= '0;
      bus.fwd_sel_a <= '0;
      bus.fwd_sel_b <= '0;
      bus.mem_en_ex <= 1'b0;
      bus.mem_rw_ex <= 1'b0;
      bus.stall_cnt <= '0;
    end else begin
      for (int i = DEPTH-1; i > 0; i--) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
        sb_ld[i] <= sb_ld[i-1];
      end
      sb_v[0]  <= issue & wr_reg;
      sb_rd[0] <= rd;
      sb_ld[0] <= is_ld;

      bus.out_valid <= issue;
      bus.mem_en_ex <= issue & (is_ld | is_st);
      bus.fwd_sel_a <= issue ? sel_a : '0;
      bus.fwd_sel_b <= issue ? sel_b : '0;
      if (issue) begin
        bus.op_dec    <= op;
        bus.imm       <= bus.ins[15:0];
        bus.imm_sel   <= is_imm;
        // non-writing instructions report r0 as their destination
        bus.dest      <= wr_reg ? rd : 5'd0;
        bus.mem_rw_ex <= is_st;
      end
      if (bus.stall && !(&bus.stall_cnt))
        bus.stall_cnt <= bus.stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_hazard_forward_unit;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int SELW     = 2;
  localparam int CNTW     = 2;
  localparam int CMAX     = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  hazard_forward_unit_if #(.SELW(SELW), .CNTW(CNTW)) bus();
  hazard_forward_unit #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SELW(SELW), .CNTW(CNTW))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [36:0] obs;
  assign obs = {bus.out_valid, bus.op_dec, bus.imm, bus.imm_sel, bus.dest,
                bus.fwd_sel_a, bus.fwd_sel_b, bus.mem_en_ex, bus.mem_rw_ex, bus.stall_cnt};

  typedef struct packed {
    logic ld, st, imm, wr, use_a, use_b;
    logic [4:0] ra, rb, rd;
    logic [5:0] op;
  } dinfo_t;
  typedef struct packed { logic v; logic [4:0] rd; logic ld; } rec_t;

  // reference state: history of the last DEPTH decode slots, youngest first
  rec_t            hist [DEPTH];
  logic            m_stall, m_vld, m_imm_sel, m_men, m_mrw;
  logic [5:0]      m_op;
  logic [15:0]     m_imm;
  logic [4:0]      m_dest;
  logic [SELW-1:0] m_sa, m_sb, e_sa, e_sb;
  int              m_cnt;
  logic            cur_v, cur_fl;
  logic [31:0]     cur_w;

  function automatic dinfo_t dec(input logic [31:0] w);
    dinfo_t d;
    int op;
    bit rt, jmpish;
    op = int'(w[31:26]);
    d.op = w[31:26];
    d.rd = w[25:21];
    d.ld = (op == 20);
    d.st = (op == 21);
    d.imm = (op >= 8 && op < 16);
    rt = (op < 8);
    jmpish = (op == 24) || (op >= 28 && op < 32);
    d.wr = (rt || d.imm || d.ld) && d.rd != 5'd0;
    d.use_a = !jmpish;
    d.ra = w[20:16];
    d.use_b = rt || d.st;
    d.rb = d.st ? w[25:21] : w[15:11];
    return d;
  endfunction

  function automatic int near(input logic use_r, input logic [4:0] r);
    if (!use_r || r == 5'd0) return -1;
    for (int i = 0; i < DEPTH; i++)
      if (hist[i].v && hist[i].rd == r) return i;
    return -1;
  endfunction

  function automatic logic [31:0] mk(input int op, input int rd, input int ra, input int rb);
    logic [31:0] w;
    w = {6'(op), 5'(rd), 5'(ra), 5'(rb), 11'h0};
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) hist[i] = '0;
    m_vld = 0; m_op = 0; m_imm = 0; m_imm_sel = 0; m_dest = 0;
    m_sa = 0; m_sb = 0; m_men = 0; m_mrw = 0; m_cnt = 0; m_stall = 0;
  endtask

  task automatic apply(input logic v, input logic [31:0] w, input logic fl);
    dinfo_t d;
    int ia, ib;
    bit hz;
    cur_v = v; cur_w = w; cur_fl = fl;
    bus.ins_valid = v; bus.ins = w; bus.flush = fl;
    #1;
    d = dec(w);
    ia = near(d.use_a, d.ra);
    ib = near(d.use_b, d.rb);
    hz = (ia >= 0 && hist[ia].ld && ia < LOAD_LAT) || (ib >= 0 && hist[ib].ld && ib < LOAD_LAT);
    m_stall = v && !fl && !reset && hz;
    e_sa = SELW'(ia + 1);
    e_sb = SELW'(ib + 1);
  endtask

  task automatic tick();
    dinfo_t d;
    bit iss;
    @(posedge clk);
    d = dec(cur_w);
    iss = cur_v && !m_stall && !cur_fl;
    if (m_stall && m_cnt < CMAX) m_cnt++;
    for (int i = DEPTH-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {iss && d.wr, d.rd, d.ld};
    m_vld = iss;
    m_men = iss && (d.ld || d.st);
    m_sa = iss ? e_sa : '0;
    m_sb = iss ? e_sb : '0;
    if (iss) begin
      m_op = d.op; m_imm = cur_w[15:0]; m_imm_sel = d.imm;
      m_dest = d.wr ? d.rd : 5'd0; m_mrw = d.st;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    apply(1'b1, mk(1, 3, 0, 0), 1'b0);
    @(posedge clk); @(posedge clk); #1;
    checks++; if (obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_alu_forward();
    apply(1, mk(1, 3, 1, 2), 0); tick();
    apply(1, mk(2, 10, 3, 4), 0);
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL alu_nostall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.fwd_sel_a !== 2'd1) begin failures++; $display("FAIL alu_fwd_a got=%0d exp=1", bus.fwd_sel_a); end
    checks++; if (bus.fwd_sel_b !== 2'd0) begin failures++; $display("FAIL alu_fwd_b got=%0d exp=0", bus.fwd_sel_b); end
    checks++; if (bus.dest !== 5'd10) begin failures++; $display("FAIL alu_dest got=%0d exp=10", bus.dest); end
    apply(1, mk(1, 11, 3, 0), 0); tick();
    checks++; if (bus.fwd_sel_a !== 2'd2) begin failures++; $display("FAIL alu_fwd_age2 got=%0d exp=2", bus.fwd_sel_a); end
  endtask

  task automatic test_load_use();
    apply(1, mk(20, 5, 0, 0), 0); tick();
    checks++; if (bus.mem_en_ex !== 1'b1 || bus.mem_rw_ex !== 1'b0) begin failures++; $display("FAIL ld_mem got=%b%b exp=10", bus.mem_en_ex, bus.mem_rw_ex); end
    apply(1, mk(1, 12, 5, 6), 0);
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", bus.stall); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b exp=0", bus.out_valid); end
    checks++; if (bus.stall_cnt !== 2'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", bus.stall_cnt); end
    apply(1, mk(1, 12, 5, 6), 0);
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.fwd_sel_a !== 2'd2) begin failures++; $display("FAIL lu_issue got=%b/%0d exp=1/2", bus.out_valid, bus.fwd_sel_a); end
    checks++; if (bus.mem_en_ex !== 1'b0) begin failures++; $display("FAIL lu_memen got=%b exp=0", bus.mem_en_ex); end
  endtask

  task automatic test_nearest_r0();
    apply(1, mk(1, 7, 0, 0), 0); tick();
    apply(1, mk(3, 7, 0, 0), 0); tick();
    apply(1, mk(1, 13, 7, 0), 0); tick();
    checks++; if (bus.fwd_sel_a !== 2'd1) begin failures++; $display("FAIL near_a got=%0d exp=1", bus.fwd_sel_a); end
    checks++; if (bus.fwd_sel_b !== 2'd0) begin failures++; $display("FAIL near_r0 got=%0d exp=0", bus.fwd_sel_b); end
    for (int k = 0; k < DEPTH; k++) begin apply(1, mk(1, 0, 0, 0), 0); tick(); end
    apply(1, mk(1, 14, 7, 0), 0); tick();
    checks++; if (bus.fwd_sel_a !== 2'd0) begin failures++; $display("FAIL near_aged got=%0d exp=0", bus.fwd_sel_a); end
  endtask

  task automatic test_store_jump();
    apply(1, mk(1, 9, 0, 0), 0); tick();
    apply(1, mk(21, 9, 0, 0), 0); tick();
    checks++; if (bus.fwd_sel_b !== 2'd1) begin failures++; $display("FAIL st_fwd_b got=%0d exp=1", bus.fwd_sel_b); end
    checks++; if ({bus.out_valid, bus.mem_en_ex, bus.mem_rw_ex} !== 3'b111) begin failures++; $display("FAIL st_mem got=%b%b%b exp=111", bus.out_valid, bus.mem_en_ex, bus.mem_rw_ex); end
    apply(1, mk(24, 9, 9, 9), 0); tick();
    checks++; if ({bus.out_valid, bus.fwd_sel_a, bus.fwd_sel_b, bus.mem_en_ex} !== 6'b100000) begin failures++; $display("FAIL jmp_issue got=%b/%0d/%0d/%b exp=1/0/0/0", bus.out_valid, bus.fwd_sel_a, bus.fwd_sel_b, bus.mem_en_ex); end
    apply(1, mk(1, 15, 9, 0), 0); tick();
    checks++; if (bus.fwd_sel_a !== 2'd3) begin failures++; $display("FAIL jmp_nowrite got=%0d exp=3", bus.fwd_sel_a); end
  endtask

  task automatic test_flush_over_stall();
    apply(1, mk(20, 2, 0, 0), 0); tick();
    apply(1, mk(1, 16, 2, 0), 1);
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL fl_bubble got=%b exp=0", bus.out_valid); end
    checks++; if (bus.stall_cnt !== 2'd1) begin failures++; $display("FAIL fl_cnt got=%0d exp=1", bus.stall_cnt); end
    apply(1, mk(1, 16, 2, 0), 0);
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL fl_next_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.fwd_sel_a !== 2'd2) begin failures++; $display("FAIL fl_next_fwd got=%0d exp=2", bus.fwd_sel_a); end
  endtask

  task automatic test_saturation_reset();
    reset = 1'b1; #1; reset = 1'b0; model_reset();
    checks++; if (bus.stall_cnt !== 2'd0) begin failures++; $display("FAIL sat_clear got=%0d exp=0", bus.stall_cnt); end
    for (int k = 0; k < 5; k++) begin
      apply(1, mk(20, 6, 0, 0), 0); tick();
      apply(1, mk(1, 17, 6, 0), 0); tick();
      apply(1, mk(1, 17, 6, 0), 0); tick();
    end
    checks++; if (bus.stall_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", bus.stall_cnt); end
    apply(1, mk(20, 8, 0, 0), 0); tick();
    apply(1, mk(1, 18, 8, 0), 0);
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL sat_stall got=%b exp=1", bus.stall); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.stall_cnt !== 2'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_async got=%0d/%b exp=0/0", bus.stall_cnt, bus.out_valid); end
    #1 reset = 1'b0;
    model_reset();
    apply(1, mk(1, 18, 8, 0), 0); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.fwd_sel_a !== 2'd0) begin failures++; $display("FAIL rst_sb_clear got=%b/%0d exp=1/0", bus.out_valid, bus.fwd_sel_a); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic v, fl;
    logic [36:0] exp_obs;
    w = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) begin
        reset = 1'b1; #1; reset = 1'b0; model_reset();
      end
      if (!m_stall || $urandom_range(3) == 0) begin
        case ($urandom_range(7))
          0, 1: w = mk($urandom_range(7), $urandom_range(5), $urandom_range(5), $urandom_range(5));
          2:    w = mk(8 + $urandom_range(7), $urandom_range(5), $urandom_range(5), $urandom_range(5));
          3:    w = mk(20, $urandom_range(5), $urandom_range(5), $urandom_range(5));
          4:    w = mk(21, $urandom_range(5), $urandom_range(5), $urandom_range(5));
          5:    w = mk(24, $urandom_range(5), $urandom_range(5), $urandom_range(5));
          6:    w = mk(28 + $urandom_range(3), $urandom_range(5), $urandom_range(5), $urandom_range(5));
          default: w = mk($urandom_range(63), $urandom_range(5), $urandom_range(5), $urandom_range(5));
        endcase
        w[10:0] = 11'($urandom);
      end
      v = ($urandom_range(9) != 0);
      fl = ($urandom_range(9) == 0);
      apply(v, w, fl);
      checks++; if (bus.stall !== m_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.stall, m_stall); end
      tick();
      exp_obs = {m_vld, m_op, m_imm, m_imm_sel, m_dest, m_sa, m_sb, m_men, m_mrw, CNTW'(m_cnt)};
      checks++; if (obs !== exp_obs) begin failures++; $display("FAIL rnd_outputs n=%0d got=%h exp=%h", n, obs, exp_obs); end
    end
  endtask

  initial begin
    bus.ins_valid = 1'b0; bus.ins = '0; bus.flush = 1'b0;
    cur_v = 0; cur_w = 0; cur_fl = 0;
    model_reset();
    test_reset();
    test_alu_forward();
    test_load_use();
    test_nearest_r0();
    test_store_jump();
    test_flush_over_stall();
    test_saturation_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised decode-stage dependency checker for the MIPS pipeline. It generalises the fixed 3-stage address tracking to a scoreboard of DEPTH in-flight destinations. It produces per-operand forwarding selects, a load-use stall with interlock, jump/flush bubble insertion and a saturating stall counter. It sits between fetch and execute: it drives the operand muxes and memory controls and holds fetch.

Parameters:
DEPTH, 3, number of in-flight stages tracked (1..7); forward source i+1 = scoreboard entry i (0 = youngest).
LOAD_LAT, 1, stages after issue during which a load result is not yet forwardable (0..DEPTH).
SELW, 2, forwarding select width, must equal clog2(DEPTH+1).
CNTW, 16, stall counter width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ins_valid  in  1  ins holds a real instruction this cycle
ins  in  32  instruction from fetch
flush  in  1  kill instruction currently in decode
stall  out  1  combinational; fetch must hold ins next cycle
out_valid  out  1  issued instruction valid in execute
op_dec  out  6  registered opcode
imm  out  16  registered ins[15:0]
imm_sel  out  1  registered immediate-class flag
dest  out  5  registered destination register
fwd_sel_a  out  SELW  operand-A source: 0 = regfile, k = scoreboard entry k-1
fwd_sel_b  out  SELW  operand-B source, same encoding
mem_en_ex  out  1  load or store in execute
mem_rw_ex  out  1  1 = store, 0 = load
stall_cnt  out  CNTW  saturating count of stall cycles

Behaviour:
- Fields: opcode ins[31:26], rd ins[25:21], rsA ins[20:16], rsB ins[15:11].
- Decode: LD = 010100; ST = 010101; JMP = 011000; CJ = 0111xx; IMM = 001xxx; RTYPE = 000xxx.
- Writes register: RTYPE, IMM or LD, and rd != 0.
- Operand A: rsA for all classes except JMP and CJ.
- Operand B: rsB for RTYPE; rd for ST (store data); otherwise unused, sel_b = 0.
- Register 0 never matches.
- Scoreboard: DEPTH entries {v, rd, is_ld}. Every cycle, entries shift 0→1→…→DEPTH-1 and the oldest drops out, regardless of stall.
- Entry 0 loads the issued instruction's record. Issue = ins_valid & ~stall & ~flush; otherwise a bubble (v = 0) is loaded.
- Forwarding: for each used operand, take the lowest index i with v & rd match. sel = i+1. No match gives sel = 0.
- Load-use stall: the operand's nearest match has is_ld = 1 and i < LOAD_LAT. With LOAD_LAT = 0, stall never asserts.
- stall = ins_valid & ~flush & (stallA | stallB).
- Jumps: JMP and CJ issue normally with no destination. Flushing the following slot is the fetch unit's job via flush.
- Registered outputs (1-cycle latency, captured at the edge where the instruction issues): out_valid, op_dec, imm, imm_sel, dest, fwd_sel_a, fwd_sel_b, mem_en_ex = LD|ST, mem_rw_ex = ST.
- On a non-issue cycle: out_valid = 0, mem_en_ex = 0, fwd_sel_* = 0, all other registered outputs hold.
- stall_cnt increments on each edge where stall = 1 and holds at all-ones.
- Simultaneous flush and hazard: flush wins, stall = 0, bubble inserted, counter does not increment.
- Reset (any time, including mid-stall): all entries invalid, all registered outputs 0, stall_cnt = 0. stall is 0 while reset is asserted.

Test Plan:
- Back-to-back ALU forwarding: issue R-type rd=3, then R-type rsA=3 rsB=4 → second issue fwd_sel_a=1, fwd_sel_b=0. A third instruction using r3 two slots later (no intervening write) → sel=2.
- Load-use: LD rd=5, then R-type rsA=5 → stall=1 for exactly 1 cycle, stall_cnt=1, bubble issued (out_valid=0). The R-type then issues with fwd_sel_a=2, mem_en_ex=0.
- Nearest-wins and r0: R-type rd=7, R-type rd=7, R-type rsA=7 rsB=0 → fwd_sel_a=1, fwd_sel_b=0. A dependence on r7 after DEPTH=3 unrelated issues → sel=0.
- Store data: R-type rd=9, then ST rd=9 → fwd_sel_b=1, mem_en_ex=1, mem_rw_ex=1. Then JMP → out_valid=1, fwd selects 0, no scoreboard write.
- Flush over stall: LD rd=2, next R-type rsA=2 with flush=1 → stall=0, out_valid=0 next cycle, stall_cnt unchanged.
- Reset/saturation: with CNTW=2, hold a load-use stall for 5 cycles → stall_cnt=3. Assert reset mid-stall asynchronously → stall_cnt=0, out_valid=0, and the following dependent instruction sees sel=0.
